// File: rtl/iir_m_decim_out.sv
// rtl/iir_m_decim_out.sv - IIR cascade output stage: boxcar decimation, round/saturate to 16 bits, FWFT result FIFO
module iir_m_decim_out #(
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [17:0]                   din,
  input  logic                          din_valid,
  input  logic                          sync,
  output logic [15:0]                   dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int AW = 18 + LOG2_DECIM;
  localparam int PW = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int QW = $clog2(FIFO_DEPTH);
  localparam int LW = QW + 1;
  localparam logic [PW-1:0] LAST_PH = PW'((1 << LOG2_DECIM) - 1);

  // ---------------- decimating accumulator ----------------
  logic [PW-1:0]        phase;
  logic [PW-1:0]        cur_phase;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] din_ext;
  logic signed [AW-1:0] acc_base;
  logic signed [AW-1:0] sum;
  logic                 block_done;
  logic signed [17:0]   avg_q;
  logic                 avg_valid;

  // sync makes the current sample (if any) the first of a fresh block
  assign cur_phase  = sync ? '0 : phase;
  assign din_ext    = AW'($signed(din));
  assign acc_base   = (cur_phase == '0) ? '0 : acc;
  assign sum        = acc_base + din_ext;
  assign block_done = din_valid && (cur_phase == LAST_PH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase     <= '0;
      acc       <= '0;
      avg_q     <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= block_done;
      if (din_valid) begin
        acc   <= sum;
        phase <= block_done ? '0 : cur_phase + PW'(1);
        if (block_done) begin
          avg_q <= sum[LOG2_DECIM +: 18];
        end
      end else if (sync) begin
        acc   <= '0;
        phase <= '0;
      end
    end
  end

  // ---------------- round half up, drop 2 LSBs, saturate ----------------
  logic signed [18:0] rnd_sum;
  logic signed [18:0] rnd;
  logic [15:0]        sat;
  logic [15:0]        conv_data;
  logic               conv_valid;

  assign rnd_sum = {avg_q[17], avg_q} + 19'sd2;
  assign rnd     = rnd_sum >>> 2;

  always_comb begin
    sat = rnd[15:0];
    if (rnd > 19'sd32767) begin
      sat = 16'h7fff;
    end else if (rnd < -19'sd32768) begin
      sat = 16'h8000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conv_data  <= '0;
      conv_valid <= 1'b0;
    end else begin
      conv_valid <= avg_valid;
      if (avg_valid) begin
        conv_data <= sat;
      end
    end
  end

  // ---------------- first-word-fall-through FIFO ----------------
  logic [15:0]   mem [FIFO_DEPTH];
  logic [QW-1:0] wr_ptr;
  logic [QW-1:0] rd_ptr;
  logic [QW-1:0] rd_next;
  logic [LW-1:0] count_next;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;

  assign full       = (level == LW'(FIFO_DEPTH));
  assign dout_valid = (level != '0);
  assign pop        = dout_valid && dout_ready;
  assign wr_en      = conv_valid && (!full || pop);
  assign drop       = conv_valid && full && !pop;
  assign rd_next    = rd_ptr + QW'(pop);
  assign count_next = level + LW'(wr_en) - LW'(pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= conv_data;
    end
  end

  // dout is a register holding the next head; bypass when the head slot is written this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + QW'(1);
      end
      rd_ptr <= rd_next;
      level  <= count_next;
      if (count_next != '0) begin
        dout <= (wr_en && (rd_next == wr_ptr)) ? conv_data : mem[rd_next];
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iir_m_decim_out.sv
// tb/tb_iir_m_decim_out.sv - directed self-checking bench for iir_m_decim_out
module tb_iir_m_decim_out;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] din = '0;
  logic        din_valid = 1'b0;
  logic        sync = 1'b0;
  logic        dout_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic [3:0]  level;
  logic        overflow;

  int n_checks = 0;
  int n_fail = 0;
  int pops = 0;
  int p0;

  iir_m_decim_out #(.LOG2_DECIM(2), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dout_valid && dout_ready) pops <= pops + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int v);
    din = 18'(v);
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic run_block(input string tag, input int a, input int b, input int c, input int d, input int exp);
    pulse(a); pulse(b); pulse(c); pulse(d);
    check({tag, "_early"}, dout_valid, 0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_valid"}, dout_valid, 1);
    check({tag, "_dout"}, $signed(dout), exp);
    @(negedge clk);
    check({tag, "_empty"}, level, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b1;
    @(negedge clk);

    // basic block with latency checks
    dout_ready = 1'b1;
    repeat (4) pulse(1000);
    check("lat_k1_valid", dout_valid, 0);
    check("lat_k1_level", level, 0);
    @(negedge clk);
    check("lat_k2_valid", dout_valid, 0);
    @(negedge clk);
    check("lat_valid", dout_valid, 1);
    check("lat_dout", $signed(dout), 250);
    check("lat_level", level, 1);
    @(negedge clk);
    check("lat_pop_level", level, 0);
    check("lat_pop_valid", dout_valid, 0);
    check("lat_hold_dout", $signed(dout), 250);

    run_block("sat_pos", 131071, 131071, 131071, 131071, 32767);
    run_block("sat_neg", -131072, -131072, -131072, -131072, -32768);
    run_block("neg6", -6, -6, -6, -6, -1);
    run_block("ramp", 1, 2, 3, 4, 1);

    // sync mid-block
    p0 = pops;
    pulse(5000); pulse(5000);
    din = 18'(400); din_valid = 1'b1; sync = 1'b1;
    @(negedge clk);
    din_valid = 1'b0; sync = 1'b0;
    pulse(400); pulse(400); pulse(400);
    check("sync_early", dout_valid, 0);
    @(negedge clk);
    @(negedge clk);
    check("sync_valid", dout_valid, 1);
    check("sync_dout", $signed(dout), 100);
    @(negedge clk);
    check("sync_words", pops - p0, 1);
    check("sync_level", level, 0);

    // overflow: 9 blocks into an 8-deep FIFO
    dout_ready = 1'b0;
    repeat (9) repeat (4) pulse(4000);
    @(negedge clk);
    @(negedge clk);
    check("full_level", level, 8);
    check("full_ovf", overflow, 1);
    check("full_dout", $signed(dout), 1000);
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", dout_valid, 1);
      check("drain_dout", $signed(dout), 1000);
      @(negedge clk);
    end
    check("drain_level", level, 0);
    check("drain_empty", dout_valid, 0);
    check("ovf_sticky", overflow, 1);
    dout_ready = 1'b0;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    // write on a pop edge while full
    repeat (8) repeat (4) pulse(4000);
    @(negedge clk);
    @(negedge clk);
    check("fp_level_pre", level, 8);
    repeat (4) pulse(800);
    @(negedge clk);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    check("fp_level", level, 8);
    check("fp_ovf", overflow, 0);
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("fp_drain", $signed(dout), (i == 7) ? 200 : 1000);
      @(negedge clk);
    end
    check("fp_level_end", level, 0);

    // asynchronous reset mid-operation
    dout_ready = 1'b0;
    repeat (3) repeat (4) pulse(4000);
    pulse(4000); pulse(4000);
    @(negedge clk);
    check("ar_level_pre", level, 3);
    #2 rst = 1'b0;
    #1;
    check("ar_dout", dout, 0);
    check("ar_valid", dout_valid, 0);
    check("ar_level", level, 0);
    check("ar_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b1;
    dout_ready = 1'b1;
    @(negedge clk);
    run_block("post_rst", 800, 800, 800, 800, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_m_decim_out.md
Name: iir_m_decim_out

Overview:
- Output stage directly downstream of the 7-section IIR cascade.
- Consumes the cascade's 18-bit signed filtered samples, qualified by a one-cycle valid pulse.
- Decimates by 2^LOG2_DECIM with boxcar averaging, rounds and saturates to 16 bits, and buffers results in a small FIFO.
- Presents the FIFO contents on a valid/ready interface to the downstream consumer; flags dropped words.

Parameters:
- LOG2_DECIM, 2, decimation factor is 2^LOG2_DECIM; legal range 0..4 (0 = no decimation, rounding/saturation only).
- FIFO_DEPTH, 8, number of 16-bit result words buffered; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous active-low reset.
- din  in  18  signed filtered sample from the IIR cascade.
- din_valid  in  1  one-cycle pulse; din is valid this cycle.
- sync  in  1  restarts the decimation phase (block alignment).
- dout  out  16  signed decimated result (FIFO head).
- dout_valid  out  1  FIFO not empty; dout holds a valid word.
- dout_ready  in  1  consumer accepts dout when dout_valid and dout_ready are both high.
- level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag; a result was dropped because the FIFO was full.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst=0, asynchronous): accumulator=0, phase counter=0, pipeline valid=0, FIFO empty, dout=0, dout_valid=0, level=0, overflow=0. Any partial block and all buffered words are discarded.
- Accumulator: signed, 18+LOG2_DECIM bits, cannot overflow. On din_valid:
  - phase 0: acc=din;
  - otherwise: acc=acc+din;
  - the counter then increments mod 2^LOG2_DECIM.
- Block complete: din_valid seen with phase = 2^LOG2_DECIM-1.
- Average: avg = (acc+din) >>> LOG2_DECIM (arithmetic shift), an 18-bit signed value.
- Output conversion: r = (avg + 2) >>> 2, computed in 19 bits. This rounds half toward +inf.
- Saturation: r > 32767 gives 32767; r < -32768 gives -32768 (the negative limit cannot be reached, but the clamp is still implemented).
- Pipeline timing for the last sample of a block accepted at edge k:
  - converted word registered at edge k+1;
  - written to the FIFO at edge k+2;
  - dout_valid high after edge k+2 (first-word-fall-through).
  - Fixed latency 2 clocks when the FIFO is not full.
- sync:
  - sync=1 forces phase=0 and discards the partial accumulation.
  - If din_valid is also high in that cycle, that sample is the first sample of the new block.
  - Words already in the conversion register or the FIFO are unaffected.
- FIFO:
  - Circular buffer; read and write pointers wrap at FIFO_DEPTH.
  - level is the exact occupancy, 0..FIFO_DEPTH.
  - Pop when dout_valid && dout_ready; dout then shows the next word (or holds its last value with dout_valid=0 when the FIFO is empty).
  - dout is stable while dout_valid=1 and dout_ready=0.
- Write while full:
  - With a simultaneous pop: the write succeeds and level stays at FIFO_DEPTH.
  - Without a pop: the word is dropped and overflow is set to 1.
- Write and pop when level=1: the word is accepted, level stays 1, and dout updates to the new word.
- overflow stays set until ovf_clr=1 or reset. If ovf_clr and a new drop occur in the same cycle, the set wins.
- dout_ready while the FIFO is empty is ignored.

Test Plan:
- LOG2_DECIM=2: 4 pulses of din=1000 with dout_ready=1 -> one word, dout=250; dout_valid rises 2 clocks after the 4th pulse; level goes 0->1->0.
- Rounding and saturation, 4-sample blocks:
  - din=131071 -> dout=32767 (saturated);
  - din=-131072 -> -32768;
  - din=-6 -> -1;
  - din={1,2,3,4} -> avg 2, dout=1.
- sync mid-block: 2 pulses of 5000, then sync together with a pulse of 400, then 3 pulses of 400 -> exactly one word, dout=100; no word produced from the 5000 samples.
- FIFO full: dout_ready=0, 9 blocks of constant 4000 with FIFO_DEPTH=8 -> level=8, overflow=1 after the 9th block. Then set dout_ready=1 -> exactly 8 words of 1000 in order, level reaches 0, dout_valid drops. Then ovf_clr -> overflow=0.
- Full with a simultaneous pop: level=8 and the next block completes on the same edge as a pop -> no drop, overflow stays 0, level=8.
- Reset mid-operation: assert rst asynchronously (between clock edges) with level=3 and a partial block of 2 samples pending -> all outputs are 0 immediately. After release, 4 fresh pulses of 800 -> first word is 200.
